// File: rtl/fixed_pkg.sv
// Q11.14 fixed-point definitions shared by the math blocks, plus the
// constants and state type used by the sequential divider.
package fixed_pkg;

  localparam int TOTAL_WIDTH   = 25;
  localparam int DECIMAL_WIDTH = 14;

  typedef logic signed [TOTAL_WIDTH-1:0] fixed;

  localparam int DIV_ITER = TOTAL_WIDTH + DECIMAL_WIDTH + 1;

  // Kept as unsigned bit patterns so zero-extension gives the saturation magnitudes.
  localparam logic [TOTAL_WIDTH-1:0] FIXED_MAX = 25'h0FFFFFF;
  localparam logic [TOTAL_WIDTH-1:0] FIXED_MIN = 25'h1000000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FINAL,
    S_DONE
  } div_state_e;

endpackage

// File: rtl/fixed_div_seq.sv
// Multi-cycle signed Q11.14 divider: radix-2 restoring loop, one quotient bit
// per clock, round half away from zero, saturation on overflow and /0.
module fixed_div_seq
  import fixed_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TOTAL_WIDTH-1:0] lhs,
  input  logic [TOTAL_WIDTH-1:0] rhs,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOTAL_WIDTH-1:0] result,
  output logic                   div_by_zero,
  output logic                   overflow
);

  div_state_e state, state_next;

  logic [5:0]             iter_cnt;
  logic [DIV_ITER-1:0]    num;
  logic [TOTAL_WIDTH-1:0] rem;
  logic [TOTAL_WIDTH-1:0] rhs_abs;
  logic                   sign;
  logic                   lhs_sign;
  logic                   lhs_zero;
  logic                   rhs_zero;

  logic                   accept;
  logic [TOTAL_WIDTH-1:0] lhs_abs_in;
  logic [TOTAL_WIDTH-1:0] rhs_abs_in;
  logic [TOTAL_WIDTH:0]   rem_shift;
  logic                   rem_ge;
  logic [DIV_ITER-1:0]    mag;
  logic [TOTAL_WIDTH-1:0] res_calc;
  logic                   ovf_calc;

  assign accept     = in_valid && in_ready;
  assign lhs_abs_in = lhs[TOTAL_WIDTH-1] ? -lhs : lhs;
  assign rhs_abs_in = rhs[TOTAL_WIDTH-1] ? -rhs : rhs;
  assign rem_shift  = {rem, num[DIV_ITER-1]};
  assign rem_ge     = rem_shift >= {1'b0, rhs_abs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_ITER;
      S_ITER:  if (iter_cnt == 6'(DIV_ITER - 1)) state_next = S_FINAL;
      S_FINAL: state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // The dividend shifts out of num's top while quotient bits enter at its bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt    <= '0;
      num         <= '0;
      rem         <= '0;
      rhs_abs     <= '0;
      sign        <= 1'b0;
      lhs_sign    <= 1'b0;
      lhs_zero    <= 1'b0;
      rhs_zero    <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          sign     <= lhs[TOTAL_WIDTH-1] ^ rhs[TOTAL_WIDTH-1];
          lhs_sign <= lhs[TOTAL_WIDTH-1];
          lhs_zero <= (lhs == '0);
          rhs_zero <= (rhs == '0);
          rhs_abs  <= rhs_abs_in;
          num      <= {lhs_abs_in, {(DECIMAL_WIDTH+1){1'b0}}};
          rem      <= '0;
          // A zero divisor makes a single pass through ITER, fixing its latency at two clocks.
          iter_cnt <= (rhs == '0) ? 6'(DIV_ITER - 1) : 6'd0;
        end
        S_ITER: begin
          rem      <= rem_ge ? TOTAL_WIDTH'(rem_shift - {1'b0, rhs_abs})
                             : rem_shift[TOTAL_WIDTH-1:0];
          num      <= {num[DIV_ITER-2:0], rem_ge};
          iter_cnt <= iter_cnt + 6'd1;
        end
        S_FINAL: begin
          result      <= res_calc;
          div_by_zero <= rhs_zero;
          overflow    <= ovf_calc;
        end
        default: ;
      endcase
    end
  end

  // num holds the quotient with one extra fraction bit, used for rounding.
  always_comb begin
    mag      = DIV_ITER'(({1'b0, num} + {{DIV_ITER{1'b0}}, 1'b1}) >> 1);
    res_calc = '0;
    ovf_calc = 1'b0;
    if (rhs_zero) begin
      if (!lhs_zero) res_calc = lhs_sign ? FIXED_MIN : FIXED_MAX;
    end else if (!sign) begin
      if (mag > DIV_ITER'(FIXED_MAX)) begin
        res_calc = FIXED_MAX;
        ovf_calc = 1'b1;
      end else begin
        res_calc = mag[TOTAL_WIDTH-1:0];
      end
    end else begin
      if (mag > DIV_ITER'(FIXED_MIN)) begin
        res_calc = FIXED_MIN;
        ovf_calc = 1'b1;
      end else begin
        res_calc = -mag[TOTAL_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fixed_div_seq.sv
// Directed bench for fixed_div_seq: hand-computed Q11.14 quotients, latency,
// saturation, divide-by-zero, backpressure and mid-operation reset.
module tb_fixed_div_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] lhs;
  logic [24:0] rhs;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] result;
  logic        div_by_zero;
  logic        overflow;

  int vectors;
  int miscompares;

  fixed_div_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .lhs        (lhs),
    .rhs        (rhs),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation from accept to consumption; time is always posedge+1 on entry and exit.
  task automatic apply_stimulus(input logic [24:0] a, input logic [24:0] b,
                                output logic [24:0] r, output logic dz,
                                output logic ov, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    lhs      = a;
    rhs      = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lhs      = 25'h0AAAAAA;
    rhs      = 25'd3;
    lat      = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 100);
    r         = result;
    dz        = div_by_zero;
    ov        = overflow;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    vectors++;
    if (result !== 25'd0) begin
      miscompares++; $display("[TB] FAIL reset_result: got %0d expected 0", $signed(result));
    end
    vectors++;
    if (div_by_zero !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_dz: got %b expected 0", div_by_zero);
    end
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_ovf: got %b expected 0", overflow);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [24:0] r; logic dz, ov; int lat;
    apply_stimulus(25'd16384, 25'd32768, r, dz, ov, lat);
    vectors++;
    if (r !== 25'd8192) begin
      miscompares++; $display("[TB] FAIL basic_result: got %0d expected 8192", $signed(r));
    end
    vectors++;
    if (lat != 41) begin
      miscompares++; $display("[TB] FAIL basic_latency: got %0d expected 41", lat);
    end
    vectors++;
    if (dz !== 1'b0) begin
      miscompares++; $display("[TB] FAIL basic_dz: got %b expected 0", dz);
    end
    vectors++;
    if (ov !== 1'b0) begin
      miscompares++; $display("[TB] FAIL basic_ovf: got %b expected 0", ov);
    end
  endtask

  task automatic test_rounding();
    int ta[3], tb[3], te[3];
    logic [24:0] r; logic dz, ov; int lat;
    ta = '{49152, 1, -1};
    tb = '{-24576, 32768, 32768};
    te = '{-32768, 1, -1};
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(25'(ta[i]), 25'(tb[i]), r, dz, ov, lat);
      vectors++;
      if (r !== 25'(te[i])) begin
        miscompares++;
        $display("[TB] FAIL round_result[%0d]: got %0d expected %0d", i, $signed(r), te[i]);
      end
      vectors++;
      if (ov !== 1'b0 || dz !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL round_flags[%0d]: got dz=%b ovf=%b expected 0 0", i, dz, ov);
      end
      vectors++;
      if (lat != 41) begin
        miscompares++; $display("[TB] FAIL round_latency[%0d]: got %0d expected 41", i, lat);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int ta[3], te[3];
    logic [24:0] r; logic dz, ov; int lat;
    ta = '{16384, -5, 0};
    te = '{16777215, -16777216, 0};
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(25'(ta[i]), 25'd0, r, dz, ov, lat);
      vectors++;
      if (r !== 25'(te[i])) begin
        miscompares++;
        $display("[TB] FAIL dz_result[%0d]: got %0d expected %0d", i, $signed(r), te[i]);
      end
      vectors++;
      if (dz !== 1'b1) begin
        miscompares++; $display("[TB] FAIL dz_flag[%0d]: got %b expected 1", i, dz);
      end
      vectors++;
      if (ov !== 1'b0) begin
        miscompares++; $display("[TB] FAIL dz_ovf[%0d]: got %b expected 0", i, ov);
      end
      vectors++;
      if (lat != 2) begin
        miscompares++; $display("[TB] FAIL dz_latency[%0d]: got %0d expected 2", i, lat);
      end
    end
  endtask

  task automatic test_overflow();
    int ta[3], tb[3], te[3];
    logic eo[3];
    logic [24:0] r; logic dz, ov; int lat;
    ta = '{16384000, -16384000, -16777216};
    tb = '{16, 16, 16384};
    te = '{16777215, -16777216, -16777216};
    eo = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(25'(ta[i]), 25'(tb[i]), r, dz, ov, lat);
      vectors++;
      if (r !== 25'(te[i])) begin
        miscompares++;
        $display("[TB] FAIL ovf_result[%0d]: got %0d expected %0d", i, $signed(r), te[i]);
      end
      vectors++;
      if (ov !== eo[i]) begin
        miscompares++; $display("[TB] FAIL ovf_flag[%0d]: got %b expected %b", i, ov, eo[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] r; logic dz, ov; int lat; int guard;
    lhs      = 25'd16384;
    rhs      = 25'd32768;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL bp_wait_valid: got %b expected 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      lhs      = 25'd99;
      rhs      = 25'd1;
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1) begin
        miscompares++; $display("[TB] FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid);
      end
      vectors++;
      if (result !== 25'd8192) begin
        miscompares++;
        $display("[TB] FAIL bp_hold_result[%0d]: got %0d expected 8192", i, $signed(result));
      end
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready);
      end
      vectors++;
      if (div_by_zero !== 1'b0 || overflow !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_flags[%0d]: got dz=%b ovf=%b expected 0 0", i, div_by_zero, overflow);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL bp_release_valid: got %b expected 0", out_valid);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    apply_stimulus(25'd49152, 25'(-24576), r, dz, ov, lat);
    vectors++;
    if (r !== 25'(-32768)) begin
      miscompares++; $display("[TB] FAIL bp_next_result: got %0d expected -32768", $signed(r));
    end
    vectors++;
    if (lat != 41) begin
      miscompares++; $display("[TB] FAIL bp_next_latency: got %0d expected 41", lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [24:0] r; logic dz, ov; int lat;
    lhs      = 25'd16384;
    rhs      = 25'd32768;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid);
    end
    vectors++;
    if (result !== 25'd0) begin
      miscompares++; $display("[TB] FAIL midrst_result: got %0d expected 0", $signed(result));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midrst_no_partial: got %b expected 0", out_valid);
    end
    apply_stimulus(25'd16384, 25'd32768, r, dz, ov, lat);
    vectors++;
    if (r !== 25'd8192) begin
      miscompares++; $display("[TB] FAIL midrst_result_after: got %0d expected 8192", $signed(r));
    end
    vectors++;
    if (lat != 41) begin
      miscompares++; $display("[TB] FAIL midrst_latency: got %0d expected 41", lat);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    lhs         = '0;
    rhs         = '0;
    rst_n       = 1'b0;
    $display("[TB] starting fixed_div_seq directed tests");
    test_reset();
    test_basic();
    test_rounding();
    test_div_by_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
